// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: drives the PLL reset, qualifies its locked flag, sequences core reset.
// Optional macro PLL_LOCK_TIMEOUT_EN: re-pulse the PLL reset when lock never arrives.
module pll_lock_sequencer #(
   parameter int RST_PULSE     = 16,
   parameter int STABLE_CYCLES = 4096,
   parameter int LOCK_TIMEOUT  = 7425000,
   parameter int CNT_W         = 24
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       core_reset,
   output logic       ready,
   output logic [7:0] relock_count,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      RESET_PLL = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE - 1);
   localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic             relock_inc;
   logic             sync_q;
   logic             lk_s;

`ifndef PLL_LOCK_TIMEOUT_EN
   logic unused_timeout;
   assign unused_timeout = ^TO_LAST;
`endif

   // Two-flop synchroniser for the asynchronous PLL locked flag
   always_ff @(posedge refclk) begin
      if (rst) begin
         sync_q <= 1'b0;
         lk_s   <= 1'b0;
      end else begin
         sync_q <= pll_locked;
         lk_s   <= sync_q;
      end
   end

   // Next-state and counter decode; counter clears on every transition
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      relock_inc = 1'b0;
      unique case (state)
         RESET_PLL: begin
            if (cnt == RST_LAST) begin
               state_nx = WAIT_LOCK;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         WAIT_LOCK: begin
            if (lk_s) begin
               state_nx = STABLE;
               cnt_nx   = '0;
`ifdef PLL_LOCK_TIMEOUT_EN
            end else if (cnt == TO_LAST) begin
               state_nx = RESET_PLL;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
`else
            end else begin
               cnt_nx = '0;
            end
`endif
         end
         STABLE: begin
            if (!lk_s) begin
               state_nx = WAIT_LOCK;
               cnt_nx   = '0;
            end else if (cnt == STB_LAST) begin
               state_nx = RUN;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         RUN: begin
            if (!lk_s) begin
               state_nx   = RESET_PLL;
               cnt_nx     = '0;
               relock_inc = 1'b1;
            end
         end
         default: begin
            state_nx = RESET_PLL;
            cnt_nx   = '0;
         end
      endcase
   end

   // State register with outputs registered from the next-state decode
   always_ff @(posedge refclk) begin
      if (rst) begin
         state        <= RESET_PLL;
         cnt          <= '0;
         pll_rst      <= 1'b1;
         core_reset   <= 1'b1;
         ready        <= 1'b0;
         relock_count <= '0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         pll_rst    <= (state_nx == RESET_PLL);
         core_reset <= (state_nx != RUN);
         ready      <= (state_nx == RUN);
         if (relock_inc && relock_count != 8'hFF)
            relock_count <= relock_count + 8'd1;
      end
   end

   assign state_dbg = state;

endmodule
